// File: rtl/pal_macrocell_array.sv
`default_nettype none
// ============================================================================
// Module   : pal_macrocell_array
// Brief    : PAL fabric with registered/inverting macrocells and a
//            double-buffered serial configuration that commits atomically.
// Revision : 1.0
// ============================================================================
module pal_macrocell_array #(
    parameter int N = 8,
    parameter int M = 6,
    parameter int P = 18
) (
    input  logic         clk,
    input  logic         res_n,
    input  logic         run_en,
    input  logic         cfg_start,
    input  logic         cfg_en,
    input  logic         cfg_bit,
    input  logic [N-1:0] in_vars,
    output logic [M-1:0] out_vals,
    output logic         cfg_busy,
    output logic         cfg_done
);

    localparam int K  = N + M;
    localparam int A  = 2 * K * P;
    localparam int B  = A + P * M;
    localparam int L  = B + 2 * M;
    localparam int CW = $clog2(L + 1);
    localparam logic [CW-1:0] L_CNT = CW'(L);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] cnt_base, cnt_inc;
    logic [L-1:0]  shadow_q;
    logic [L-1:0]  active_q;
    logic [M-1:0]  mc_q;
    logic          done_q;
    logic          shift_en;
    logic          commit;

    logic [K-1:0]  lits;
    logic [P-1:0]  term;
    logic [M-1:0]  or_v;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shift_en = 1'b0;
        commit   = 1'b0;
        cnt_base = cfg_start ? '0 : count_q;
        cnt_inc  = cnt_base + CW'(1);
        case (state_q)
            ST_IDLE, ST_LOAD: begin
                count_d = cnt_base;
                if (cfg_start) begin
                    state_d = ST_IDLE;
                end
                // A restart in the same cycle as a bit makes that bit bit 0.
                if (cfg_en) begin
                    shift_en = 1'b1;
                    count_d  = cnt_inc;
                    state_d  = (cnt_inc == L_CNT) ? ST_COMMIT : ST_LOAD;
                end
            end
            ST_COMMIT: begin
                commit  = 1'b1;
                count_d = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            shadow_q <= '0;
            active_q <= '0;
            mc_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= commit;
            if (shift_en) begin
                shadow_q <= {cfg_bit, shadow_q[L-1:1]};
            end
            if (commit) begin
                active_q <= shadow_q;
            end
            // Commit restarts every macrocell from a known zero state.
            if (commit) begin
                mc_q <= '0;
            end else if (run_en) begin
                mc_q <= or_v;
            end
        end
    end

    // Feedback always comes from the flops, so the AND plane has no loops.
    assign lits = {mc_q, in_vars};

    for (genvar p = 0; p < P; p++) begin : g_term
        logic [K-1:0] mask_t;
        logic [K-1:0] mask_c;
        for (genvar j = 0; j < K; j++) begin : g_lit
            assign mask_t[j] = active_q[p*2*K + 2*j];
            assign mask_c[j] = active_q[p*2*K + 2*j + 1];
        end
        assign term[p] = (|(mask_t | mask_c)) &
                         ~(|((mask_t & ~lits) | (mask_c & lits)));
    end

    for (genvar m = 0; m < M; m++) begin : g_mc
        assign or_v[m]     = |(term & active_q[A + m*P +: P]);
        assign out_vals[m] = (active_q[B + 2*m] ? mc_q[m] : or_v[m])
                             ^ active_q[B + 2*m + 1];
    end

    assign cfg_busy = (state_q != ST_IDLE);
    assign cfg_done = done_q;

endmodule
`default_nettype wire

// File: doc/pal_macrocell_array.md
Name: pal_macrocell_array

Overview:
- Parametrised successor to the team's serially-configured PAL fabric.
- Adds macrocells: each output can be combinational or registered, with programmable inversion. Registered state feeds back into the AND plane.
- Configuration is double-buffered. Bits stream into a shadow register while the active fabric keeps running. The new image is committed atomically once the full image has loaded.
- Sits directly behind the chip-level wrapper: configuration pins drive cfg_*, dedicated inputs drive in_vars, dedicated outputs are driven from out_vals.

Parameters:
- N, 8, number of external input variables.
- M, 6, number of outputs/macrocells.
- P, 18, number of product terms.
- Derived: K = N+M (AND-plane literals), A = 2*K*P, B = A + P*M, L = B + 2*M (total config bits; 624 at defaults).

Ports:
- clk  in  1  fabric and configuration clock.
- res_n  in  1  asynchronous active-low reset.
- run_en  in  1  clock enable for macrocell flops.
- cfg_start  in  1  synchronous restart of the configuration bit counter.
- cfg_en  in  1  qualifies cfg_bit in the current cycle.
- cfg_bit  in  1  serial configuration data.
- in_vars  in  N  input variables.
- out_vals  out  M  macrocell outputs.
- cfg_busy  out  1  high while a load is in progress or a commit is pending.
- cfg_done  out  1  one-cycle pulse: new configuration is active.

Behaviour:
- Reset (async, res_n=0): shadow, active config, macrocell flops, counter all 0; state IDLE; cfg_busy=0; cfg_done=0; out_vals=0. With an all-zero config every OR is 0, so outputs are 0.
- Shift: when cfg_en=1 in IDLE/LOAD, shadow <= {cfg_bit, shadow[L-1:1]} and count++. The first bit shifted ends at index 0 after L shifts.
- cfg_en=0: shadow and count hold, so a load may pause indefinitely.
- Config layout (active index):
  - Literal j of term p: p*2K+2j selects the true literal, p*2K+2j+1 selects the complement.
  - Literals j<N are in_vars[j]; literals j>=N are fb[j-N].
  - OR select of term p into output m: A + m*P + p.
  - reg_sel[m] = B+2m; inv[m] = B+2m+1.
- Product term: AND of all selected literals. A term with an empty mask evaluates 0. True and complement of the same literal both selected evaluates 0.
- or_m = OR of selected terms.
- Macrocell flop q_m <= or_m on each clk edge with run_en=1; holds otherwise.
- fb[m] = q_m regardless of reg_sel (no combinational loops).
- out_vals[m] = (reg_sel[m] ? q_m : or_m) XOR inv[m].
  - Combinational path: zero latency from in_vars.
  - Registered path: 1 enabled cycle.
- FSM:
  - IDLE: count=0. cfg_en -> LOAD, or -> COMMIT if L=1.
  - LOAD: the shift that brings count to L -> COMMIT.
  - COMMIT: exactly one cycle. At its closing edge: active <= shadow, all q_m <= 0, count <= 0, cfg_done <= 1, state -> IDLE. cfg_en/cfg_bit are ignored in COMMIT (bit dropped).
- cfg_done: registered, high for exactly the first cycle in which the new config is visible.
- cfg_busy = (state != IDLE).
- cfg_start in IDLE/LOAD: count <= 0, state -> IDLE; shadow contents irrelevant (fully overwritten by L shifts).
  - cfg_start with cfg_en in the same cycle: the bit is accepted as bit 0 (count=1, LOAD).
  - cfg_start is ignored in COMMIT.
- Active config is never partially updated. Fabric behaviour during load uses the old image.
- Reset mid-load or mid-commit: everything returns to reset values; a partial load is discarded.

Test Plan (N=4, M=2, P=4 → K=6, A=48, B=56, L=60):
- After reset, in_vars=4'hF -> out_vals=2'b00, cfg_busy=0, cfg_done=0. Stream 60 bits with bits 0,2,48 set:
  - cfg_busy=1 from bit 1 through COMMIT.
  - cfg_done pulses once, the cycle after COMMIT.
  - in_vars=4'b0011 -> out_vals[0]=1 same cycle; 4'b0001 -> 0.
- Toggle flop: bits 9 (!fb0), 48, 56 set, run_en=1 -> out_vals[0] sequence 0,1,0,1 per cycle. run_en=0 for 3 cycles -> value holds.
- Inversion: only bit 57 set -> out_vals=2'b01 from the cfg_done cycle. Previous toggle flop is cleared to 0 at commit.
- Pause/restart: 20 bits, cfg_en low 10 cycles, then cfg_start, then full 60-bit image -> exactly one cfg_done; active config equals the second image.
- Reset mid-load: after 30 bits, res_n=0 for 1 cycle -> out_vals=0, cfg_busy=0, old active config cleared. A following 60-bit load commits normally.
- Empty/contradictory terms: term0 mask = bits 0 and 1 (in0 & !in0) OR'd into out0, term1 empty mask OR'd into out1 -> out_vals=2'b00 for all 16 in_vars values.
